// File: rtl/instr_decode_reg.sv
// -----------------------------------------------------------------------------
// instr_decode_reg
//
// Registered instruction-decode buffer placed directly upstream of the
// sign/zero extend unit. Fetched 32-bit MIPS words are accepted with their PC
// over a valid/ready handshake. They are held in a 2-entry skid buffer
// (head + skid). The head word is presented split into MIPS fields.
// Every field output comes straight from the head register, so there is no
// combinational path from in_instr to the decode outputs.
//
// Optional feature macro: INSTR_COUNT_EN
//   defined   -> instr_count is a free-running 32-bit count of consumed words
//   undefined -> instr_count is tied to zero and no counter register exists
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    fetch-side handshake, carrying in_instr and in_pc
//   flush                synchronous discard of every buffered word
//   out_valid/out_ready  consume-side handshake for the head entry
//   out_pc               PC of the head entry
//   opcode .. jtarget    field slices of the head instruction
//                        (imm16 feeds the extend unit's data_in)
//   itype                0 = R, 1 = I, 2 = J
//   instr_count          consumed-instruction counter (zero when disabled)
// -----------------------------------------------------------------------------
module instr_decode_reg #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm16,
  output logic [25:0]     jtarget,
  output logic [1:0]      itype,
  output logic [31:0]     instr_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       head_instr_q, head_instr_d;
  logic [PC_W-1:0]   head_pc_q, head_pc_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic              in_fire;
  logic              out_fire;

  // Handshake flags depend only on the registered state, never on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and storage update; flush overrides every transition.
  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      state_d      = ST_EMPTY;
      head_instr_d = NOP_WORD;
      head_pc_d    = {PC_W{1'b0}};
      skid_instr_d = NOP_WORD;
      skid_pc_d    = {PC_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_instr_d = in_instr;
            head_pc_d    = in_pc;
            state_d      = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
            state_d      = ST_FULL;
          end else if (in_fire && out_fire) begin
            head_instr_d = in_instr;
            head_pc_d    = in_pc;
            state_d      = ST_ONE;
          end else if (out_fire) begin
            // Draining to empty: the field outputs fall back to the NOP word.
            head_instr_d = NOP_WORD;
            head_pc_d    = {PC_W{1'b0}};
            state_d      = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            head_instr_d = skid_instr_q;
            head_pc_d    = skid_pc_q;
            skid_instr_d = NOP_WORD;
            skid_pc_d    = {PC_W{1'b0}};
            state_d      = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          head_instr_d = NOP_WORD;
          head_pc_d    = {PC_W{1'b0}};
          skid_instr_d = NOP_WORD;
          skid_pc_d    = {PC_W{1'b0}};
        end
      endcase
    end
  end

  // State and storage registers with asynchronous reset to the empty/NOP state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      head_instr_q <= NOP_WORD;
      head_pc_q    <= {PC_W{1'b0}};
      skid_instr_q <= NOP_WORD;
      skid_pc_q    <= {PC_W{1'b0}};
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Field outputs are slices of the head register.
  assign out_pc  = head_pc_q;
  assign opcode  = head_instr_q[31:26];
  assign rs      = head_instr_q[25:21];
  assign rt      = head_instr_q[20:16];
  assign rd      = head_instr_q[15:11];
  assign shamt   = head_instr_q[10:6];
  assign funct   = head_instr_q[5:0];
  assign imm16   = head_instr_q[15:0];
  assign jtarget = head_instr_q[25:0];

  // Format class of the head opcode: SPECIAL is R, J/JAL are J, the rest are I.
  always_comb begin
    itype = 2'd1;
    case (head_instr_q[31:26])
      6'd0:       itype = 2'd0;
      6'd2, 6'd3: itype = 2'd2;
      default:    itype = 2'd1;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] count_q, count_d;

  // Consumed-word count; a consume in a flush cycle still counts, wraps at 2^32.
  always_comb begin
    if (out_fire) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'h0;
`endif

endmodule
